// File: rtl/serial_word_receiver.sv
// ---------------------------------------------------------------------------
// serial_word_receiver
// Serial-in / parallel-out receiver at the far end of the 4-bit universal
// shift-register link. Collects WIDTH qualified serial bits, MSB-first or
// LSB-first, and offers the assembled word on a valid/ready handshake.
//
// Ports
//   CP         in   clock, all state changes on posedge
//   CR         in   synchronous active-low reset
//   start      in   one-cycle pulse: begin a new word, latch dir
//   dir        in   0 = MSB-first, 1 = LSB-first (sampled with start)
//   sin        in   serial data bit
//   sin_en     in   serial bit qualifier (used only while shifting)
//   par_q      out  assembled word, stable while par_valid = 1
//   par_valid  out  word available
//   par_ready  in   consumer accepts word when par_valid & par_ready
//   busy       out  high while shifting
//   overrun    out  sticky: start arrived while an unaccepted word was held
//   ovr_clr    in   clears overrun, wins over a coincident set
// ---------------------------------------------------------------------------
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             start,
  input  logic             dir,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] par_q,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_par_q;
  logic             r_par_valid;
  logic             r_busy;
  logic             r_overrun;

  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] w_sr_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_dir_nxt;
  logic [WIDTH-1:0] w_par_q_nxt;
  logic             w_ovr_set;
  logic             w_ovr_nxt;
  logic [WIDTH-1:0] w_sr_shift;

  // Shift register with the incoming bit inserted according to the latched order.
  assign w_sr_shift = r_dir ? {sin, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], sin};

  // Next-state and datapath decode for the IDLE / SHIFT / DONE controller.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_par_q_nxt = r_par_q;
    w_ovr_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
          w_sr_nxt    = {WIDTH{1'b0}};
          w_cnt_nxt   = CNT_ZERO;
          w_dir_nxt   = dir;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          // Abort the partial word; the bit offered this cycle is discarded.
          w_state_nxt = ST_SHIFT;
          w_sr_nxt    = {WIDTH{1'b0}};
          w_cnt_nxt   = CNT_ZERO;
          w_dir_nxt   = dir;
        end else if (sin_en) begin
          w_sr_nxt  = w_sr_shift;
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_par_q_nxt = w_sr_shift;
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SHIFT;
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (par_ready) begin
          if (start) begin
            // Back-to-back: hand off and start the next word without an IDLE gap.
            w_state_nxt = ST_SHIFT;
            w_sr_nxt    = {WIDTH{1'b0}};
            w_cnt_nxt   = CNT_ZERO;
            w_dir_nxt   = dir;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (start) begin
          // Held word not yet taken: drop the start and flag it.
          w_ovr_set   = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sticky overrun flag; clear takes priority over a coincident set.
  always_comb begin
    w_ovr_nxt = r_overrun;
    if (ovr_clr) begin
      w_ovr_nxt = 1'b0;
    end else if (w_ovr_set) begin
      w_ovr_nxt = 1'b1;
    end else begin
      w_ovr_nxt = r_overrun;
    end
  end

  // State, datapath and registered status outputs with synchronous reset.
  always_ff @(posedge CP) begin
    if (!CR) begin
      r_state     <= ST_IDLE;
      r_sr        <= {WIDTH{1'b0}};
      r_cnt       <= CNT_ZERO;
      r_dir       <= 1'b0;
      r_par_q     <= {WIDTH{1'b0}};
      r_par_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_sr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dir       <= w_dir_nxt;
      r_par_q     <= w_par_q_nxt;
      // Status flags are decoded from the next state so they track r_state exactly.
      r_par_valid <= (w_state_nxt == ST_DONE);
      r_busy      <= (w_state_nxt == ST_SHIFT);
      r_overrun   <= w_ovr_nxt;
    end
  end

  assign par_q     = r_par_q;
  assign par_valid = r_par_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_word_receiver.sv
// ---------------------------------------------------------------------------
// tb_serial_word_receiver
// Directed bench for serial_word_receiver with a 4-bit and an 8-bit instance.
// Expected words come from a bit-order model and pass through scoreboard
// queues: pushed when the last bit is driven, popped when the word is offered.
// ---------------------------------------------------------------------------
module tb_serial_word_receiver;

  logic       CP = 1'b0;
  logic       CR;
  logic       ovr_clr;

  logic       start4, dir4, sin4, en4, rdy4;
  logic [3:0] q4;
  logic       v4, b4, o4;

  logic       start8, dir8, sin8, en8, rdy8;
  logic [7:0] q8;
  logic       v8, b8, o8;

  logic [31:0] sb4[$];
  logic [31:0] sb8[$];

  int vectors     = 0;
  int miscompares = 0;

  serial_word_receiver #(.WIDTH(4)) u_dut4 (
    .CP(CP), .CR(CR), .start(start4), .dir(dir4), .sin(sin4), .sin_en(en4),
    .par_q(q4), .par_valid(v4), .par_ready(rdy4), .busy(b4), .overrun(o4),
    .ovr_clr(ovr_clr)
  );

  serial_word_receiver #(.WIDTH(8)) u_dut8 (
    .CP(CP), .CR(CR), .start(start8), .dir(dir8), .sin(sin8), .sin_en(en8),
    .par_q(q8), .par_valid(v8), .par_ready(rdy8), .busy(b8), .overrun(o8),
    .ovr_clr(ovr_clr)
  );

  always #5 CP = ~CP;

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word model: seq[n-1] is the first bit on the wire.
  function automatic logic [31:0] model(input logic [31:0] seq, input int n, input logic d);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = n - 1; i >= 0; i--) begin
      if (d) acc = (acc >> 1) | (32'(seq[i]) << (n - 1));
      else   acc = (acc << 1) | 32'(seq[i]);
    end
    return acc;
  endfunction

  task automatic start4_pulse(input logic d);
    start4 = 1'b1; dir4 = d;
    step();
    start4 = 1'b0;
    check("w4_busy_after_start", 32'(b4), 32'd1);
  endtask

  task automatic start8_pulse(input logic d);
    start8 = 1'b1; dir8 = d;
    step();
    start8 = 1'b0;
    check("w8_busy_after_start", 32'(b8), 32'd1);
  endtask

  task automatic bits4(input logic [3:0] seq, input int nb, input logic d, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps) repeat (i) step();
      sin4 = seq[3-i]; en4 = 1'b1;
      if (i == 3) sb4.push_back(model(32'(seq), 4, d));
      step();
      en4 = 1'b0; sin4 = 1'b0;
      if (i < 3) check("w4_valid_early", 32'(v4), 32'd0);
    end
  endtask

  task automatic bits8(input logic [7:0] seq, input logic d);
    for (int i = 0; i < 8; i++) begin
      sin8 = seq[7-i]; en8 = 1'b1;
      if (i == 7) sb8.push_back(model(32'(seq), 8, d));
      step();
      en8 = 1'b0; sin8 = 1'b0;
      if (i < 7) check("w8_valid_early", 32'(v8), 32'd0);
    end
  endtask

  task automatic take4(input string tag);
    logic [31:0] exp;
    check({tag, "_valid"}, 32'(v4), 32'd1);
    if (sb4.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb4.pop_front();
      check(tag, 32'(q4), exp);
    end
  endtask

  task automatic take8(input string tag);
    logic [31:0] exp;
    check({tag, "_valid"}, 32'(v8), 32'd1);
    if (sb8.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb8.pop_front();
      check(tag, 32'(q8), exp);
    end
  endtask

  task automatic release4(input string tag);
    rdy4 = 1'b1;
    step();
    rdy4 = 1'b0;
    check({tag, "_valid_drop"}, 32'(v4), 32'd0);
    check({tag, "_busy_idle"}, 32'(b4), 32'd0);
  endtask

  initial begin
    CR = 1'b0; ovr_clr = 1'b0;
    start4 = 1'b0; dir4 = 1'b0; sin4 = 1'b0; en4 = 1'b0; rdy4 = 1'b0;
    start8 = 1'b0; dir8 = 1'b0; sin8 = 1'b0; en8 = 1'b0; rdy8 = 1'b0;
    step(); step();
    check("rst_par_q", 32'(q4), 32'd0);
    check("rst_valid", 32'(v4), 32'd0);
    check("rst_busy", 32'(b4), 32'd0);
    check("rst_overrun", 32'(o4), 32'd0);
    check("rst_w8_par_q", 32'(q8), 32'd0);
    CR = 1'b1;
    step();

    // 1: MSB-first, consecutive bits 1,0,1,1 -> 4'b1011
    start4_pulse(1'b0);
    bits4(4'b1011, 4, 1'b0, 1'b0);
    take4("t1_word");
    check("t1_busy_done", 32'(b4), 32'd0);
    check("t1_const", 32'(q4), 32'hB);
    release4("t1");

    // 2: LSB-first, gaps 0..3 cycles -> 4'b1101
    start4_pulse(1'b1);
    bits4(4'b1011, 4, 1'b1, 1'b1);
    take4("t2_word");
    check("t2_const", 32'(q4), 32'hD);

    // 3: overrun while word held, then clear beats coincident set
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    check("t3_overrun_set", 32'(o4), 32'd1);
    check("t3_par_q_held", 32'(q4), 32'hD);
    check("t3_still_valid", 32'(v4), 32'd1);
    ovr_clr = 1'b1; start4 = 1'b1;
    step();
    ovr_clr = 1'b0; start4 = 1'b0;
    check("t3_overrun_clr", 32'(o4), 32'd0);
    check("t3_valid_kept", 32'(v4), 32'd1);
    release4("t3");

    // 4: reset in mid-word, IDLE ignores sin_en, then 0,1,1,0 MSB-first
    start4_pulse(1'b0);
    bits4(4'b1011, 2, 1'b0, 1'b0);
    CR = 1'b0;
    step();
    CR = 1'b1;
    check("t4_rst_par_q", 32'(q4), 32'd0);
    check("t4_rst_busy", 32'(b4), 32'd0);
    check("t4_rst_valid", 32'(v4), 32'd0);
    sin4 = 1'b1; en4 = 1'b1;
    step();
    sin4 = 1'b0; en4 = 1'b0;
    check("t4_idle_ignores_sin", 32'(b4), 32'd0);
    start4_pulse(1'b0);
    bits4(4'b0110, 4, 1'b0, 1'b0);
    take4("t4_word");
    release4("t4");

    // 5: abort after two bits (bit offered with start is dropped), then 1,1,0,0
    start4_pulse(1'b0);
    bits4(4'b0101, 2, 1'b0, 1'b0);
    start4 = 1'b1; dir4 = 1'b0; sin4 = 1'b1; en4 = 1'b1;
    step();
    start4 = 1'b0; sin4 = 1'b0; en4 = 1'b0;
    check("t5_abort_busy", 32'(b4), 32'd1);
    check("t5_abort_no_valid", 32'(v4), 32'd0);
    bits4(4'b1100, 4, 1'b0, 1'b0);
    take4("t5_word");

    // 6a: ready + start in DONE -> straight back to SHIFT
    rdy4 = 1'b1; start4 = 1'b1; dir4 = 1'b1;
    step();
    rdy4 = 1'b0; start4 = 1'b0;
    check("t6_b2b_busy", 32'(b4), 32'd1);
    check("t6_b2b_valid", 32'(v4), 32'd0);
    bits4(4'b0011, 4, 1'b1, 1'b0);
    take4("t6_w4_word");
    release4("t6_w4");

    // 6b: WIDTH=8 LSB-first 0xA5, then back-to-back MSB-first 0x3C
    start8_pulse(1'b1);
    bits8(8'hA5, 1'b1);
    take8("t6_w8_a5");
    check("t6_w8_const", 32'(q8), 32'hA5);
    rdy8 = 1'b1; start8 = 1'b1; dir8 = 1'b0;
    step();
    rdy8 = 1'b0; start8 = 1'b0;
    check("t6_w8_b2b_busy", 32'(b8), 32'd1);
    check("t6_w8_b2b_valid", 32'(v8), 32'd0);
    bits8(8'h3C, 1'b0);
    take8("t6_w8_3c");
    rdy8 = 1'b1;
    step();
    rdy8 = 1'b0;
    check("t6_w8_release", 32'(v8), 32'd0);
    check("t6_w8_overrun", 32'(o8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
